decode_queue: RTL

Parametrised, buffered RV32 instruction decoder for the fetch-to-execute boundary. Each accepted instruction word is decoded on entry, and the pre-decoded result is stored in a DEPTH-entry FIFO. The FIFO is drained with a valid/ready handshake, and a flush can drop it in one cycle. The block generalises the single-word combinational decoder with queue depth, an RV32E register-file mode, an optional M extension, and back-pressure.

---
 rtl/decode_queue.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_queue.sv
// Buffered RV32 pre-decoder: each accepted word is decoded on entry and held,
// with its decode, in a DEPTH-entry FIFO drained by a valid/ready handshake.
module decode_queue #(
  parameter int DEPTH    = 4,
  parameter bit EMBEDDED = 1'b0,
  parameter bit MULDIV   = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_pc,
  input  logic [31:0]            in_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_instr,
  output logic [31:0]            out_imm,
  output logic [4:0]             out_waddr,
  output logic [4:0]             out_raddr1,
  output logic [4:0]             out_raddr2,
  output logic                   out_wren,
  output logic                   out_rden1,
  output logic                   out_rden2,
  output logic [3:0]             out_class,
  output logic                   out_illegal,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] CLS_ALU    = 4'd0;
  localparam logic [3:0] CLS_LUI    = 4'd1;
  localparam logic [3:0] CLS_AUIPC  = 4'd2;
  localparam logic [3:0] CLS_JAL    = 4'd3;
  localparam logic [3:0] CLS_JALR   = 4'd4;
  localparam logic [3:0] CLS_BRANCH = 4'd5;
  localparam logic [3:0] CLS_LOAD   = 4'd6;
  localparam logic [3:0] CLS_STORE  = 4'd7;
  localparam logic [3:0] CLS_MULDIV = 4'd8;
  localparam logic [3:0] CLS_CSR    = 4'd9;
  localparam logic [3:0] CLS_FENCE  = 4'd10;
  localparam logic [3:0] CLS_SYSTEM = 4'd11;
  localparam logic [3:0] CLS_ILL    = 4'd15;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] imm;
    logic        wren;
    logic        rden1;
    logic        rden2;
    logic [3:0]  cls;
    logic        illegal;
  } entry_t;

  // ---------------------------------------------------------------- decode
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [11:0] f12;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign opc   = in_instr[6:0];
  assign rd    = in_instr[11:7];
  assign f3    = in_instr[14:12];
  assign rs1   = in_instr[19:15];
  assign rs2   = in_instr[24:20];
  assign f7    = in_instr[31:25];
  assign f12   = in_instr[31:20];
  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};

  logic [3:0]  dec_cls;
  logic [31:0] dec_imm;
  logic        dec_wr;
  logic        dec_r1;
  logic        dec_r2;
  logic        dec_bad;
  logic        reg_bad;
  logic        dec_ill;
  entry_t      dec_entry;

  always_comb begin
    dec_cls = CLS_ALU;
    dec_imm = '0;
    dec_wr  = 1'b0;
    dec_r1  = 1'b0;
    dec_r2  = 1'b0;
    dec_bad = 1'b0;
    case (opc)
      OPC_LUI:   begin dec_cls = CLS_LUI;   dec_imm = imm_u; dec_wr = 1'b1; end
      OPC_AUIPC: begin dec_cls = CLS_AUIPC; dec_imm = imm_u; dec_wr = 1'b1; end
      OPC_JAL:   begin dec_cls = CLS_JAL;   dec_imm = imm_j; dec_wr = 1'b1; end
      OPC_JALR: begin
        dec_cls = CLS_JALR;
        dec_imm = imm_i;
        dec_wr  = 1'b1;
        dec_r1  = 1'b1;
      end
      OPC_BRANCH: begin
        dec_cls = CLS_BRANCH;
        dec_imm = imm_b;
        dec_r1  = 1'b1;
        dec_r2  = 1'b1;
        dec_bad = (f3 == 3'd2) || (f3 == 3'd3);
      end
      OPC_LOAD: begin
        dec_cls = CLS_LOAD;
        dec_imm = imm_i;
        dec_wr  = 1'b1;
        dec_r1  = 1'b1;
        dec_bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      OPC_STORE: begin
        dec_cls = CLS_STORE;
        dec_imm = imm_s;
        dec_r1  = 1'b1;
        dec_r2  = 1'b1;
        dec_bad = (f3 > 3'd2);
      end
      OPC_OPIMM: begin
        dec_cls = CLS_ALU;
        dec_imm = imm_i;
        dec_wr  = 1'b1;
        dec_r1  = 1'b1;
        // only shifts constrain the upper bits; srai is the one 0x20 form
        if (f3 == 3'd1)      dec_bad = (f7 != 7'h00);
        else if (f3 == 3'd5) dec_bad = (f7 != 7'h00) && (f7 != 7'h20);
      end
      OPC_OP: begin
        dec_wr = 1'b1;
        dec_r1 = 1'b1;
        dec_r2 = 1'b1;
        case (f7)
          7'h00:   dec_cls = CLS_ALU;
          7'h20:   dec_bad = (f3 != 3'd0) && (f3 != 3'd5);
          7'h01: begin
            dec_cls = CLS_MULDIV;
            dec_bad = !MULDIV;
          end
          default: dec_bad = 1'b1;
        endcase
      end
      OPC_FENCE: begin
        dec_cls = CLS_FENCE;
        dec_imm = imm_i;
        dec_bad = (f3 > 3'd1);
      end
      OPC_SYSTEM: begin
        dec_imm = imm_i;
        if (f3 == 3'd0) begin
          dec_cls = CLS_SYSTEM;
          dec_bad = (f12 != 12'h000) && (f12 != 12'h001) &&
                    (f12 != 12'h302) && (f12 != 12'h105);
        end else if (f3 == 3'd4) begin
          dec_bad = 1'b1;
        end else begin
          // funct3[2] selects the immediate form, whose rs1 field is the operand
          dec_cls = CLS_CSR;
          dec_wr  = 1'b1;
          dec_r1  = !f3[2];
          if (f3[2]) dec_imm = {27'b0, rs1};
        end
      end
      default: dec_bad = 1'b1;
    endcase
  end

  assign reg_bad = EMBEDDED && ((dec_wr && rd[4]) || (dec_r1 && rs1[4]) || (dec_r2 && rs2[4]));
  assign dec_ill = dec_bad || reg_bad;

  always_comb begin
    dec_entry.pc      = in_pc;
    dec_entry.instr   = in_instr;
    dec_entry.imm     = dec_imm;
    dec_entry.wren    = !dec_ill && dec_wr && (rd != 5'd0);
    dec_entry.rden1   = !dec_ill && dec_r1;
    dec_entry.rden2   = !dec_ill && dec_r2;
    dec_entry.cls     = dec_ill ? CLS_ILL : dec_cls;
    dec_entry.illegal = dec_ill;
  end

  // ---------------------------------------------------------------- fifo
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] wptr_d;
  logic [AW-1:0] rptr_q;
  logic [AW-1:0] rptr_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          push;
  logic          pop;
  entry_t        mem_q [DEPTH];
  entry_t        head;

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // storage is don't-care after reset; occupancy alone qualifies it
  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= dec_entry;
  end

  assign head = mem_q[rptr_q];

  always_comb begin
    out_pc      = '0;
    out_instr   = '0;
    out_imm     = '0;
    out_waddr   = '0;
    out_raddr1  = '0;
    out_raddr2  = '0;
    out_wren    = 1'b0;
    out_rden1   = 1'b0;
    out_rden2   = 1'b0;
    out_class   = '0;
    out_illegal = 1'b0;
    if (out_valid) begin
      out_pc      = head.pc;
      out_instr   = head.instr;
      out_imm     = head.imm;
      out_waddr   = head.instr[11:7];
      out_raddr1  = head.instr[19:15];
      out_raddr2  = head.instr[24:20];
      out_wren    = head.wren;
      out_rden1   = head.rden1;
      out_rden2   = head.rden2;
      out_class   = head.cls;
      out_illegal = head.illegal;
    end
  end

endmodule
